// File: rtl/upsample_layer_pkg.sv
// Shared definitions for the nearest-neighbour upsampling layer:
// FSM state encoding and counter width helpers.
package upsample_layer_pkg;

    typedef enum logic {
        FILL   = 1'b0,
        REPLAY = 1'b1
    } state_e;

    function automatic int XWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int YWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int RepWidth(input int scale);
        return (scale <= 1) ? 1 : $clog2(scale);
    endfunction

endpackage

// File: rtl/upsample_layer_line_replay_buffer.sv
// One-row pixel store: written while a row streams in, replayed for the
// vertical repeats through an asynchronous read port.
module line_replay_buffer #(
    parameter int Depth     = 16,
    parameter int Width     = 1,
    parameter int AddrWidth = 4
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [Width-1:0]     wdata_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [Width-1:0]     rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/upsample_layer.sv
// Nearest-neighbour upsampler: each input pixel becomes a Scale x Scale block.
// Horizontal repeats hold the output register; vertical repeats replay one row.
module upsample_layer
    import upsample_layer_pkg::*;
#(
    parameter int LineWidthPx = 16,
    parameter int LineCountPx = 12,
    parameter int WidthIn     = 1,
    parameter int InChannels  = 1,
    parameter int Scale       = 2,
    localparam int OutChannels = InChannels,
    localparam int WidthOut    = WidthIn
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  valid_i,
    output logic                                  ready_o,
    input  logic [InChannels-1:0][WidthIn-1:0]    data_i,
    output logic                                  valid_o,
    input  logic                                  ready_i,
    output logic [OutChannels-1:0][WidthOut-1:0]  data_o
);

    localparam int XW = XWidth(LineWidthPx);
    localparam int YW = YWidth(LineCountPx);
    localparam int RW = RepWidth(Scale);
    localparam int PW = InChannels * WidthIn;

    localparam logic [XW-1:0] X_LAST   = XW'(LineWidthPx - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(LineCountPx - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(Scale - 1);

    state_e          state_q, state_d;
    logic [XW-1:0]   x_pos_q, x_pos_d;
    logic [RW-1:0]   x_rep_q, x_rep_d;
    logic [RW-1:0]   y_rep_q, y_rep_d;
    logic [YW-1:0]   y_pos_q, y_pos_d;
    logic            valid_q, valid_d;
    logic [PW-1:0]   data_q,  data_d;

    logic            last_rep, row_end, out_fire, pixel_done, slot_free;
    logic            in_fire, replay_load;
    logic [PW-1:0]   buf_rdata;

    assign last_rep   = (x_rep_q == REP_LAST);
    assign row_end    = (x_pos_q == X_LAST);
    assign out_fire   = valid_q & ready_i;
    assign pixel_done = out_fire & last_rep;
    assign slot_free  = ~valid_q | (ready_i & last_rep);

    // Counter advance happens when the last horizontal repeat leaves.
    always_comb begin
        x_rep_d = x_rep_q;
        x_pos_d = x_pos_q;
        y_rep_d = y_rep_q;
        y_pos_d = y_pos_q;
        if (out_fire) begin
            x_rep_d = last_rep ? '0 : x_rep_q + RW'(1);
        end
        if (pixel_done) begin
            if (row_end) begin
                x_pos_d = '0;
                if (y_rep_q == REP_LAST) begin
                    y_rep_d = '0;
                    y_pos_d = (y_pos_q == Y_LAST) ? '0 : y_pos_q + YW'(1);
                end else begin
                    y_rep_d = y_rep_q + RW'(1);
                end
            end else begin
                x_pos_d = x_pos_q + XW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (pixel_done && row_end && (Scale > 1)) begin
                    state_d = REPLAY;
                end
            end
            REPLAY: begin
                if (pixel_done && row_end && (y_rep_q == REP_LAST)) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // The next pixel loads into the slot being vacated, so its source and
    // buffer address follow the post-advance state and x position.
    assign ready_o     = ~rst_i & slot_free & (state_d == FILL);
    assign in_fire     = valid_i & ready_o;
    assign replay_load = ~rst_i & slot_free & (state_d == REPLAY);

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q & ~pixel_done;
        if (in_fire) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end else if (replay_load) begin
            data_d  = buf_rdata;
            valid_d = 1'b1;
        end
    end

    line_replay_buffer #(
        .Depth     (LineWidthPx),
        .Width     (PW),
        .AddrWidth (XW)
    ) u_line_buf (
        .clk_i   (clk_i),
        .we_i    (in_fire),
        .waddr_i (x_pos_d),
        .wdata_i (data_i),
        .raddr_i (x_pos_d),
        .rdata_o (buf_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FILL;
            x_pos_q <= '0;
            x_rep_q <= '0;
            y_rep_q <= '0;
            y_pos_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            x_pos_q <= x_pos_d;
            x_rep_q <= x_rep_d;
            y_rep_q <= y_rep_d;
            y_pos_q <= y_pos_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: tb/tb_upsample_layer.sv
// Randomised and directed checks of upsample_layer in three geometries against
// a frame-level model: expected output stream plus expected acceptance points.
module tb_upsample_layer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // k=0: Scale 1, 4x2, 2x4-bit channels
    logic v1, r1, rdy1, vo1;
    logic [7:0] d1, q1;
    // k=1: Scale 2, 2x2, 4-bit
    logic v2, r2, rdy2, vo2;
    logic [3:0] d2, q2;
    // k=2: Scale 3, 3x1, 4-bit
    logic v3, r3, rdy3, vo3;
    logic [3:0] d3, q3;

    upsample_layer #(.LineWidthPx(4), .LineCountPx(2), .WidthIn(4), .InChannels(2), .Scale(1)) u_s1 (
        .clk_i(clk), .rst_i(rst), .valid_i(v1), .ready_o(rdy1), .data_i(d1),
        .valid_o(vo1), .ready_i(r1), .data_o(q1));

    upsample_layer #(.LineWidthPx(2), .LineCountPx(2), .WidthIn(4), .InChannels(1), .Scale(2)) u_s2 (
        .clk_i(clk), .rst_i(rst), .valid_i(v2), .ready_o(rdy2), .data_i(d2),
        .valid_o(vo2), .ready_i(r2), .data_o(q2));

    upsample_layer #(.LineWidthPx(3), .LineCountPx(1), .WidthIn(4), .InChannels(1), .Scale(3)) u_s3 (
        .clk_i(clk), .rst_i(rst), .valid_i(v3), .ready_o(rdy3), .data_i(d3),
        .valid_o(vo3), .ready_i(r3), .data_o(q3));

    int errors = 0;
    int checks = 0;
    logic [7:0] in_q[$];
    logic [7:0] exp_q[$];
    int oc[3];
    int ac[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int geom_w(input int k);
        return (k == 0) ? 4 : (k == 1) ? 2 : 3;
    endfunction
    function automatic int geom_h(input int k);
        return (k == 0) ? 2 : (k == 1) ? 2 : 1;
    endfunction
    function automatic int geom_s(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 3;
    endfunction

    task automatic drive(input int k, input logic v, input logic [7:0] d, input logic r);
        case (k)
            0:       begin v1 = v; d1 = d;      r1 = r; end
            1:       begin v2 = v; d2 = d[3:0]; r2 = r; end
            default: begin v3 = v; d3 = d[3:0]; r3 = r; end
        endcase
    endtask

    task automatic sample(input int k, output logic rdy, output logic vo, output logic [7:0] q);
        case (k)
            0:       begin rdy = rdy1; vo = vo1; q = q1;         end
            1:       begin rdy = rdy2; vo = vo2; q = {4'h0, q2}; end
            default: begin rdy = rdy3; vo = vo3; q = {4'h0, q3}; end
        endcase
    endtask

    task automatic idle_all();
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        drive(2, 1'b0, 8'h00, 1'b0);
    endtask

    // Output index at which input pixel p (counted since reset) is first emitted.
    function automatic int start_of(input int k, input int p);
        int w, h, s, f, i;
        w = geom_w(k); h = geom_h(k); s = geom_s(k);
        f = p / (w * h);
        i = p % (w * h);
        return f * w * h * s * s + (i / w) * w * s * s + (i % w) * s;
    endfunction

    // Queue one frame of input and the Scale x Scale block expansion it implies.
    task automatic add_frame(input int k, input logic [7:0] pix[$]);
        int w, h, s;
        w = geom_w(k); h = geom_h(k); s = geom_s(k);
        foreach (pix[i]) in_q.push_back(pix[i]);
        for (int r = 0; r < h; r++)
            for (int yr = 0; yr < s; yr++)
                for (int c = 0; c < w; c++)
                    for (int xr = 0; xr < s; xr++)
                        exp_q.push_back(pix[r * w + c]);
    endtask

    task automatic add_random_frame(input int k);
        logic [7:0] pix[$];
        for (int i = 0; i < geom_w(k) * geom_h(k); i++)
            pix.push_back((k == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)));
        add_frame(k, pix);
    endtask

    // rmode: 0 ready_i always high, 1 toggle 1,0,..., 2 random.
    task automatic run_stream(input int k, input int max_cycles, input int pv, input int rmode,
                              input int stop_outs, input bit cont);
        int cyc, outs;
        logic v, r, rdy, vo, fire, tog, stalled, acc_prev;
        logic [7:0] d, q, held, acc_d, e;
        cyc = 0; outs = 0; tog = 1'b1; stalled = 1'b0; acc_prev = 1'b0;
        held = '0; acc_d = '0;
        while (exp_q.size() > 0 && (stop_outs < 0 || outs < stop_outs) && cyc < max_cycles) begin
            v = (in_q.size() > 0) && ($urandom_range(0, 99) < pv);
            d = v ? in_q[0] : 8'($urandom);
            case (rmode)
                0:       r = 1'b1;
                1:       begin r = tog; tog = ~tog; end
                default: r = 1'($urandom_range(0, 1));
            endcase
            drive(k, v, d, r);
            @(negedge clk);
            sample(k, rdy, vo, q);
            fire = vo & r;
            check("ready_o", 32'(rdy), 32'((oc[k] + int'(fire)) == start_of(k, ac[k])));
            if (acc_prev) check("latency", 32'({vo, q}), 32'({1'b1, acc_d}));
            if (stalled) check("hold", 32'({vo, q}), 32'({1'b1, held}));
            if (cont && cyc > 0) check("no_bubble", 32'(vo), 32'd1);
            if (fire) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                check("data_o", 32'(q), 32'(e));
                $display("k=%0d out#%0d data_o=%0h expected=%0h", k, oc[k], q, e);
                oc[k]++;
                outs++;
            end
            acc_prev = v & rdy;
            if (acc_prev) begin
                acc_d = d;
                void'(in_q.pop_front());
                ac[k]++;
            end
            stalled = vo & ~r;
            held = q;
            cyc++;
            @(posedge clk);
            #1;
        end
        if (stop_outs < 0) check("drained", 32'(exp_q.size()), 32'd0);
        drive(k, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic clear_model();
        in_q.delete();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin oc[i] = 0; ac[i] = 0; end
    endtask

    // Holds reset for one edge, then checks reset-time and post-reset outputs.
    task automatic pulse_reset();
        logic rdy, vo;
        logic [7:0] q;
        rst = 1'b1;
        idle_all();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sample(k, rdy, vo, q);
            check("ready_in_reset", 32'(rdy), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sample(k, rdy, vo, q);
            check("rst_valid_o", 32'(vo), 32'd0);
            check("rst_data_o", 32'(q), 32'd0);
            check("rst_ready_o", 32'(rdy), 32'd1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pix[$];
        rst = 1'b1;
        idle_all();
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        pulse_reset();

        // Scale 2: pixels 1,2,3,4 with ready_i high, continuous output
        pix = '{8'd1, 8'd2, 8'd3, 8'd4};
        add_frame(1, pix);
        run_stream(1, 200, 100, 0, -1, 1'b1);

        // Same frame with ready_i toggling
        add_frame(1, pix);
        run_stream(1, 200, 100, 1, -1, 1'b0);

        // Two back-to-back random frames, no bubble across the frame boundary
        add_random_frame(1);
        add_random_frame(1);
        run_stream(1, 200, 100, 0, -1, 1'b1);

        // Random valid/ready on Scale 2
        add_random_frame(1);
        add_random_frame(1);
        run_stream(1, 1000, 60, 2, -1, 1'b0);

        // Scale 3: A,B,C replicated into 27 outputs
        pix = '{8'hA, 8'hB, 8'hC};
        add_frame(2, pix);
        run_stream(2, 200, 100, 0, -1, 1'b1);

        // Scale 1 elastic pass-through under random handshakes
        for (int f = 0; f < 3; f++) add_random_frame(0);
        run_stream(0, 1000, 60, 2, -1, 1'b0);

        // Reset in the middle of the first replay row, then a clean frame
        add_random_frame(1);
        run_stream(1, 200, 100, 0, 6, 1'b1);
        pulse_reset();
        pix = '{8'd5, 8'd6, 8'd7, 8'd8};
        add_frame(1, pix);
        run_stream(1, 200, 100, 0, -1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/upsample_layer.md
# upsample_layer

Nearest-neighbour upsampling layer: the inverse of the team's max-pool layer in the streaming CNN pipeline. It accepts a raster-order image of LineWidthPx × LineCountPx multichannel pixels over a valid/ready stream. It emits a (LineWidthPx·Scale) × (LineCountPx·Scale) image in which every input pixel becomes a Scale × Scale block. Horizontal repeats come from holding the output register. Vertical repeats replay a one-row line buffer.

## Interface
- LineWidthPx, 16, input pixels per row (≥1)
- LineCountPx, 12, input rows per frame (≥1)
- WidthIn, 1, bits per channel
- InChannels, 1, channels per pixel; OutChannels = InChannels, WidthOut = WidthIn (localparams)
- Scale, 2, replication factor in both dimensions (≥1)
- clk_i  in  1  single clock; all state updates on its rising edge
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  input pixel valid
- ready_o  out  1  input pixel accepted when valid_i & ready_o
- data_i  in  [InChannels-1:0][WidthIn-1:0]  input pixel
- valid_o  out  1  output pixel valid
- ready_i  in  1  downstream ready
- data_o  out  [OutChannels-1:0][WidthOut-1:0]  output pixel

## Operation
- Fire signals: in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
- Counters (all reset to 0):
  - x_pos: 0..LineWidthPx-1
  - x_rep: 0..Scale-1
  - y_rep: 0..Scale-1
  - y_pos: 0..LineCountPx-1
- Output stage: a single register holding valid_r and data_r; valid_o = valid_r, data_o = data_r.
- Two-state FSM:
  - FILL: y_rep == 0; pixels come from data_i.
  - REPLAY: y_rep ≥ 1; pixels come from the line buffer at x_pos.
- FILL behaviour:
  - ready_o = (state == FILL) & slot_free, where slot_free = ~valid_r | (ready_i & x_rep == Scale-1).
  - On in_fire: data_i is loaded into data_r, valid_r is set, and data_i is written to line buffer[x_pos].
- REPLAY behaviour:
  - ready_o = 0.
  - When slot_free, line buffer[x_pos] (asynchronous read) is loaded into data_r and valid_r is set.
- Horizontal repeat: each out_fire increments x_rep.
  - At x_rep == Scale-1, x_rep wraps to 0 and x_pos advances.
  - valid_r clears unless a new load happens in the same cycle.
- Row end (x_pos == LineWidthPx-1 and last horizontal repeat fires):
  - x_pos wraps to 0 and y_rep increments.
  - When y_rep == Scale-1, y_rep wraps to 0, y_pos advances, and state returns to FILL.
- FSM transitions:
  - FILL→REPLAY at row end when Scale > 1.
  - REPLAY→FILL at row end of replay y_rep == Scale-1.
  - Scale == 1: the block never enters REPLAY and acts as a one-deep elastic pass-through.
- Frame end: after the last row's last repeat, y_pos wraps to 0; the next input pixel starts a new frame.
- The line buffer is written only in FILL and read only in REPLAY, so no read/write collision is possible.

## Timing
- Reset values:
  - valid_o = 0; data_o = 0; state = FILL; all counters = 0.
  - ready_o = 0 while rst_i is high and 1 in the first cycle after release.
- Latency: an input accepted at cycle t appears on data_o at t+1.
- Throughput:
  - FILL: one input per Scale cycles with ready_i held high.
  - Output: one pixel per cycle with no bubbles, including across the FILL↔REPLAY and row boundaries.
- Handshake rules:
  - While valid_o is high and ready_i is low, data_o and valid_o hold stable.
  - ready_o never depends combinationally on valid_i.
  - A simultaneous last-repeat out_fire and in_fire (FILL) reloads data_r in the same cycle with no bubble.
- Reset mid-row or mid-replay: all state returns to reset values next cycle, the pending output is dropped, and line buffer contents are don't-care.

## Structure
- Shared layer package holds:
  - the state enum typedef (FILL, REPLAY);
  - width helpers XWidth and YWidth, each computed as (N ≤ 1) ? 1 : $clog2(N);
  - RepWidth, computed as (Scale ≤ 1) ? 1 : $clog2(Scale).
- One sub-module, line_replay_buffer:
  - LineWidthPx × (InChannels·WidthIn) storage;
  - synchronous write port with enable and address;
  - asynchronous read port with address.

## Test plan
- LineWidthPx=2, LineCountPx=2, Scale=2, WidthIn=4, input pixels 1,2,3,4 with ready_i=1 → output 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4; valid_o continuous; ready_o high 1 of every 2 cycles during FILL, low throughout REPLAY.
- Same configuration with ready_i toggled 1,0 each cycle → identical output sequence; data_o stable while stalled; no duplication or loss.
- Scale=1, LineWidthPx=4, random valid_i and ready_i → output equals input order exactly, one-cycle latency.
- Scale=3, LineWidthPx=3, LineCountPx=1, pixels A,B,C → 27 outputs AAABBBCCC repeated 3 times; ready_o low for exactly the two replay rows.
- Assert rst_i mid-REPLAY on frame 1, then send frame 2 → valid_o=0 the cycle after reset; frame 2 output is fully correct with no frame-1 residue.
- Two back-to-back frames with valid_i=1 continuously → y_pos wraps correctly and frame 2's first output appears with no bubble after frame 1's last.
